uart_tx: RTL and testbench

// - Serializing UART transmitter. Sits directly downstream of the message source.
// - Takes bytes over a req/cts handshake; drives 8N1-style frames on o_serial.

---
 rtl/uart_tx.sv | 115 +++++++++++
 tb/tb_uart_tx.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// Serializing UART transmitter: accepts bytes over a req/cts handshake and
// drives start, 8 data bits LSB-first and configurable stop bits on o_serial.
module uart_tx #(
  parameter int cycles_per_bit = 4,
  parameter int stop_bits      = 1
) (
  input  logic       clock,
  input  logic       i_rstn,
  input  logic [7:0] i_data,
  input  logic       i_req,
  output logic       o_serial,
  output logic       o_cts,
  output logic       o_idle
);

  localparam int CW = (cycles_per_bit > 1) ? $clog2(cycles_per_bit) : 1;
  localparam logic [CW-1:0] CYC_LAST      = CW'(cycles_per_bit - 1);
  localparam logic [3:0]    BIT_LAST_DATA = 4'd8;
  localparam logic [3:0]    BIT_LAST      = 4'(8 + stop_bits);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cyc_cnt, cyc_next;
  logic [3:0]    bit_cnt, bit_next;
  logic [7:0]    shreg, shreg_next;
  logic          bit_end;
  logic          accept;

  assign bit_end = (cyc_cnt == CYC_LAST);
  assign accept  = o_cts && i_req;

  always_ff @(posedge clock) begin
    if (!i_rstn) begin
      state   <= IDLE;
      cyc_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= 8'hFF;
    end else begin
      state   <= state_next;
      cyc_cnt <= cyc_next;
      bit_cnt <= bit_next;
      shreg   <= shreg_next;
    end
  end

  // Outputs depend on registered state only, so i_req never reaches o_cts.
  always_comb begin
    o_serial = 1'b1;
    o_cts    = 1'b0;
    o_idle   = 1'b0;
    case (state)
      IDLE: begin
        o_cts  = 1'b1;
        o_idle = 1'b1;
      end
      START:   o_serial = 1'b0;
      DATA:    o_serial = shreg[0];
      STOP:    o_cts    = bit_end && (bit_cnt == BIT_LAST);
      default: o_serial = 1'b1;
    endcase
  end

  always_comb begin
    state_next = state;
    cyc_next   = bit_end ? '0 : cyc_cnt + CW'(1);
    bit_next   = bit_cnt;
    shreg_next = shreg;
    case (state)
      IDLE: begin
        cyc_next = '0;
        bit_next = '0;
        if (accept) begin
          shreg_next = i_data;
          state_next = START;
        end
      end
      START: begin
        if (bit_end) begin
          bit_next   = 4'd1;
          state_next = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          bit_next   = bit_cnt + 4'd1;
          shreg_next = {1'b1, shreg[7:1]};
          if (bit_cnt == BIT_LAST_DATA) state_next = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (bit_cnt == BIT_LAST) begin
            // Accepting here chains the next start bit with no gap cycle.
            bit_next = '0;
            if (accept) begin
              shreg_next = i_data;
              state_next = START;
            end else begin
              state_next = IDLE;
            end
          end else begin
            bit_next = bit_cnt + 4'd1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        cyc_next   = '0;
        bit_next   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus queues per-cycle expected line/cts/idle
// values, and one monitor per instance pops and compares them on the falling edge.
module tb_uart_tx;

  typedef struct {
    int    cyc;
    logic  ser;
    logic  cts;
    logic  idle;
    string name;
  } exp_t;

  logic       clock = 1'b0;
  logic       rstn_a, req_a, rstn_b, req_b;
  logic [7:0] data_a, data_b;
  logic       ser_a, cts_a, idle_a, ser_b, cts_b, idle_b;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fails = 0;
  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  uart_tx #(.cycles_per_bit(4), .stop_bits(1)) dut_a (
    .clock(clock), .i_rstn(rstn_a), .i_data(data_a), .i_req(req_a),
    .o_serial(ser_a), .o_cts(cts_a), .o_idle(idle_a)
  );

  uart_tx #(.cycles_per_bit(2), .stop_bits(2)) dut_b (
    .clock(clock), .i_rstn(rstn_b), .i_data(data_b), .i_req(req_b),
    .o_serial(ser_b), .o_cts(cts_b), .o_idle(idle_b)
  );

  always #5 clock = ~clock;

  // cyc holds k during the cycle that follows posedge k.
  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input exp_t e, input logic ser, input logic cts, input logic idle);
    n_checks += 3;
    if (ser !== e.ser) begin
      n_fails++;
      $display("[TB] FAIL %s cyc=%0d serial got %b want %b", e.name, e.cyc, ser, e.ser);
    end
    if (cts !== e.cts) begin
      n_fails++;
      $display("[TB] FAIL %s cyc=%0d cts got %b want %b", e.name, e.cyc, cts, e.cts);
    end
    if (idle !== e.idle) begin
      n_fails++;
      $display("[TB] FAIL %s cyc=%0d idle got %b want %b", e.name, e.cyc, idle, e.idle);
    end
  endtask

  always @(negedge clock) begin
    while (qa.size() > 0 && qa[0].cyc <= cyc) begin
      ea = qa.pop_front();
      if (ea.cyc < cyc) begin
        n_checks++;
        n_fails++;
        $display("[TB] FAIL %s_a missed cyc=%0d now %0d", ea.name, ea.cyc, cyc);
      end else begin
        checkOutput(ea, ser_a, cts_a, idle_a);
      end
    end
  end

  always @(negedge clock) begin
    while (qb.size() > 0 && qb[0].cyc <= cyc) begin
      eb = qb.pop_front();
      if (eb.cyc < cyc) begin
        n_checks++;
        n_fails++;
        $display("[TB] FAIL %s_b missed cyc=%0d now %0d", eb.name, eb.cyc, cyc);
      end else begin
        checkOutput(eb, ser_b, cts_b, idle_b);
      end
    end
  end

  task automatic pushExp(input bit to_b, input int c, input logic s, input logic ct,
                         input logic id, input string name);
    exp_t x;
    x.cyc = c; x.ser = s; x.cts = ct; x.idle = id; x.name = name;
    if (to_b) qb.push_back(x);
    else      qa.push_back(x);
  endtask

  task automatic pushIdle(input bit to_b, input int from_c, input int to_c, input string name);
    for (int c = from_c; c <= to_c; c++) pushExp(to_b, c, 1'b1, 1'b1, 1'b1, name);
  endtask

  // Relative cycle r (1-based after accept edge e) lives at absolute cyc e+r-1.
  task automatic pushFrame(input bit to_b, input int e, input logic [7:0] d, input int cpb,
                           input int sb, input int rmax, input string name);
    int   f;
    logic s;
    f = (9 + sb) * cpb;
    for (int r = 1; r <= rmax; r++) begin
      if (r <= cpb)          s = 1'b0;
      else if (r <= 9 * cpb) s = d[(r - cpb - 1) / cpb];
      else                   s = 1'b1;
      pushExp(to_b, e + r - 1, s, (r == f), 1'b0, name);
    end
  endtask

  task automatic waitUntil(input int t);
    while (cyc < t) @(negedge clock);
  endtask

  task automatic applyStimulus(input bit to_b, input logic req, input logic [7:0] d);
    if (to_b) begin req_b = req; data_b = d; end
    else      begin req_a = req; data_a = d; end
  endtask

  initial begin
    int e, e2, k;
    rstn_a = 1'b1; rstn_b = 1'b1;
    req_a = 1'b0;  req_b = 1'b0;
    data_a = 8'h00; data_b = 8'h00;

    @(negedge clock);
    k = cyc;
    rstn_a = 1'b0; rstn_b = 1'b0;
    pushIdle(0, k + 1, k + 4, "reset");
    pushIdle(1, k + 1, k + 4, "reset");
    waitUntil(k + 3);
    rstn_a = 1'b1; rstn_b = 1'b1;
    waitUntil(k + 5);

    e = cyc + 1;
    applyStimulus(0, 1'b1, 8'h55);
    pushFrame(0, e, 8'h55, 4, 1, 40, "single");
    pushIdle(0, e + 40, e + 43, "single_idle");
    waitUntil(e);
    applyStimulus(0, 1'b0, 8'h55);
    waitUntil(e + 44);

    e = cyc + 1;
    applyStimulus(0, 1'b1, 8'hA5);
    pushFrame(0, e, 8'hA5, 4, 1, 40, "b2b_first");
    pushFrame(0, e + 40, 8'h3C, 4, 1, 40, "b2b_second");
    pushIdle(0, e + 80, e + 83, "b2b_idle");
    waitUntil(e);
    applyStimulus(0, 1'b1, 8'h3C);
    waitUntil(e + 40);
    applyStimulus(0, 1'b0, 8'h3C);
    waitUntil(e + 84);

    e = cyc + 1;
    applyStimulus(0, 1'b1, 8'h0F);
    pushFrame(0, e, 8'h0F, 4, 1, 40, "busy");
    pushIdle(0, e + 40, e + 45, "busy_idle");
    waitUntil(e);
    applyStimulus(0, 1'b0, 8'h0F);
    waitUntil(e + 9);
    applyStimulus(0, 1'b1, 8'hF0);
    waitUntil(e + 20);
    applyStimulus(0, 1'b0, 8'hF0);
    waitUntil(e + 46);

    e  = cyc + 1;
    e2 = e + 17;
    applyStimulus(0, 1'b1, 8'hFF);
    pushFrame(0, e, 8'hFF, 4, 1, 15, "midreset_pre");
    pushIdle(0, e + 15, e + 16, "midreset_idle");
    pushFrame(0, e2, 8'hC3, 4, 1, 40, "midreset_new");
    pushIdle(0, e2 + 40, e2 + 43, "midreset_end");
    waitUntil(e);
    applyStimulus(0, 1'b0, 8'hFF);
    waitUntil(e + 14);
    rstn_a = 1'b0;
    waitUntil(e + 15);
    rstn_a = 1'b1;
    waitUntil(e + 16);
    applyStimulus(0, 1'b1, 8'hC3);
    waitUntil(e + 17);
    applyStimulus(0, 1'b0, 8'hC3);
    waitUntil(e2 + 44);

    e = cyc + 1;
    applyStimulus(1, 1'b1, 8'h80);
    pushFrame(1, e, 8'h80, 2, 2, 22, "sweep");
    pushIdle(1, e + 22, e + 25, "sweep_idle");
    waitUntil(e);
    applyStimulus(1, 1'b0, 8'h80);
    waitUntil(e + 26);

    for (int i = 0; i < 100 && (qa.size() > 0 || qb.size() > 0); i++) @(negedge clock);
    if (qa.size() > 0 || qb.size() > 0) begin
      n_checks++;
      n_fails++;
      $display("[TB] FAIL drain pending got %0d entries want 0", qa.size() + qb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
